// File: rtl/seq_cla_adder.sv
// rtl/seq_cla_adder.sv - sequential add/subtract unit, one 4-bit carry-lookahead slice per cycle
// Define SEQ_CLA_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SEQ_CLA_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int SLICE  = 4;
    localparam int NCHUNK = WIDTH / SLICE;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] s_chunk;
    logic             c1;
    logic             c2;
    logic             c3;
    logic             c4;
    logic             grp_g;
    logic             grp_p;
    logic             accept;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res;
    assign accept    = in_valid && (state == IDLE);
    assign last      = (idx == LAST_IDX);

    // Per-bit lookahead for c1..c3, group generate/propagate for the slice carry-out.
    always_comb begin
        g       = a_reg[idx*SLICE +: SLICE] & b_reg[idx*SLICE +: SLICE];
        p       = a_reg[idx*SLICE +: SLICE] ^ b_reg[idx*SLICE +: SLICE];
        c1      = g[0] | (p[0] & carry);
        c2      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & carry);
        grp_g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
        grp_p   = &p;
        c4      = grp_g | (grp_p & carry);
        s_chunk = p ^ {c3, c2, c1, carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the carry register doubles as the "+1".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            cout  <= 1'b0;
`ifdef SEQ_CLA_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == RUN) begin
            res[idx*SLICE +: SLICE] <= s_chunk;
            carry <= c4;
            idx   <= idx + 1'b1;
            if (last) begin
                cout <= c4;
`ifdef SEQ_CLA_ADDER_OVF_EN
                ovf  <= c3 ^ c4;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_cla_adder.sv
// tb/tb_seq_cla_adder.sv - scoreboard bench for seq_cla_adder with directed vectors
module tb_seq_cla_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SEQ_CLA_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    seq_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SEQ_CLA_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got sum %0h with no request pending", sum);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
`ifdef SEQ_CLA_ADDER_OVF_EN
                chk("ovf", ovf, e.o);
`endif
            end
        end
    end

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic sb, input logic [W-1:0] es, input logic ec, input logic eo);
        a = av;
        b = bv;
        cin = ci;
        sub = sb;
        in_valid = 1'b1;
        exp_q.push_back('{es, ec, eo});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic sb, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        drive(av, bv, ci, sb, es, ec, eo);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        chk("busy_run", busy, 1);
        chk("in_ready_run", in_ready, 0);
        wait_valid(n);
        chk("latency", n, W / 4);
        @(posedge clk);
        #1;
        chk("idle_after", in_ready, 1);
        chk("valid_drop", out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int hs;
        int acc;
        logic rdy;
        logic vh;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SEQ_CLA_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        run_op(32'h0000000F, 32'h00000001, 1'b1, 1'b0, 32'h00000011, 1'b0, 1'b0);
        run_op(32'h0000000A, 32'h00000003, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0);
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
        run_op(32'h89ABCDEF, 32'h76543210, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Backpressure: hold DONE while requests and operands churn.
        drive(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        wait_valid(n);
        chk("bp_latency", n, W / 4);
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            sub = i[0];
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", sum, 32'hFFFFFFFE);
            chk("bp_cout", cout, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", in_ready, 1);
        chk("bp_valid_drop", out_valid, 0);

        // Reset pulse in the middle of RUN.
        a = 32'hDEADBEEF;
        b = 32'h01234567;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        chk("mid_rst_no_valid", cnt, 0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

        // Back-to-back with in_valid held high.
        drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        hs = -1;
        acc = -1;
        for (int k = 1; k <= 30; k++) begin
            rdy = in_ready;
            vh = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (vh && hs < 0) hs = k;
            if (rdy && in_valid) begin
                acc = k;
                break;
            end
        end
        chk("b2b_handshake_edge", hs, W / 4 + 1);
        chk("b2b_accept_edge", acc, W / 4 + 2);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_cla_adder.md
SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a multiple of 4 in the range 8..64; local constant SLICE = 4 is the lookahead slice width.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry-in; used for add only.
REQ-009 Port: sub  input  1  1 = A minus B, 0 = A plus B plus cin.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: sum  output  WIDTH  result.
REQ-013 Port: cout  output  1  final carry-out.
REQ-014 Port: busy  output  1  high in RUN and DONE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 exactly when the state is IDLE; it is a combinational decode of the state.
REQ-017 Accept: at a rising edge with in_valid=1 and in_ready=1, the block SHALL latch A, B' (= ~B when sub=1, else B) and carry (= 1 when sub=1, else cin), clear the chunk index to 0 and enter RUN.
REQ-018 RUN, per cycle: the block SHALL take 4-bit chunk idx of A and B'; compute g=A&B' and p=A^B'; form carries c1..c4 with two-level lookahead from g, p and the carry register; write sum bits p^{c0..c3} into chunk idx of the result register; load c4 into the carry register; then increment idx.
REQ-019 After processing chunk WIDTH/4-1, the block SHALL enter DONE, assert out_valid and drive cout from the final c4.
REQ-020 Latency: with the accept edge counted as edge 0, out_valid SHALL be high after edge WIDTH/4 (edge 8 when WIDTH=32).
REQ-021 DONE: sum, cout and out_valid SHALL hold stable until an edge with out_ready=1; at that edge the block SHALL return to IDLE and deassert out_valid.
REQ-022 No new request SHALL be accepted in the DONE-to-IDLE edge; the earliest next accept is the following edge.
REQ-023 in_valid and the operand inputs SHALL be ignored outside IDLE; the latched operands SHALL be unaffected by input changes during RUN.
REQ-024 Width rules: the carry out of each chunk is the only inter-cycle state; arithmetic wraps modulo 2^WIDTH.
REQ-025 For sub=1, cout=1 SHALL mean no borrow (A >= B, unsigned).

Reset
REQ-026 While rst_n=0, independent of clk: state=IDLE, idx=0, carry=0, result register=0, out_valid=0, sum=0, cout=0, busy=0; in_ready=1.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-028 The first accept after reset release SHALL be possible at the first rising edge with rst_n=1.

Configuration
REQ-029 Macro: SEQ_CLA_ADDER_OVF_EN.
REQ-030 When SEQ_CLA_ADDER_OVF_EN is defined, the block SHALL add port ovf (output, 1 bit) = carry into the MSB XOR final carry-out (signed overflow). ovf SHALL be valid and held with out_valid and reset to 0.
REQ-031 When SEQ_CLA_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=32)
REQ-032 Add carry-chain case: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> out_valid after edge 8, sum=0x00000000, cout=1, ovf=0.
REQ-033 Subtract case: A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
REQ-034 Signed overflow case (macro on): A=0x7FFFFFFF, B=1, add -> sum=0x80000000, cout=0, ovf=1.
REQ-035 Backpressure case: out_ready=0 for 5 cycles in DONE while in_valid=1 and operands change -> sum, cout and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-036 Mid-operation reset: rst_n pulsed low after edge 3 of RUN -> outputs at reset values immediately and no out_valid; then A=0x12345678, B=0x11111111 -> sum=0x23456789, cout=0.
REQ-037 Back-to-back requests: in_valid held high with two requests and out_ready=1 -> second accept occurs exactly 1 edge after the DONE handshake; both results are correct.
